busrq_arbiter: RTL

//  Shares the Z80 bus between the CPU and two DMA requesters (req[0], req[1]) via BUSRQ/BUSAK.

---
 rtl/busrq_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/busrq_arbiter.sv
// Purpose: shares the Z80 bus between the CPU and two DMA requesters through BUSRQ/BUSAK.
// Latency: BUSRQ falls one clkcpu edge after a request is seen in IDLE; gnt rises the edge after BUSAK is sampled low.
// Backpressure: grants are capped at MAX_BURST T-states and always followed by MIN_GAP T-states of CPU ownership.
module busrq_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int MIN_GAP   = 4,
  parameter bit INT_GUARD = 1'b1
) (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       n_rstcpu,
  input  logic       n_int_next,
  input  logic [1:0] req,
  input  logic       n_busak,
  output logic       n_busrq,
  output logic [1:0] gnt,
  output logic       busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } state_t;

  state_t        state, state_nx;
  logic          win, win_nx;
  logic          last, last_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic          n_busrq_nx;
  logic [1:0]    gnt_nx;
  logic          int_block;

  // A pending INT pulse only blocks the start of a new arbitration, never a running one.
  assign int_block = INT_GUARD && !n_int_next;

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_nx   = state;
    win_nx     = win;
    last_nx    = last;
    bcnt_nx    = bcnt;
    gcnt_nx    = gcnt;
    n_busrq_nx = n_busrq;
    gnt_nx     = gnt;
    unique case (state)
      ST_IDLE: begin
        if (|req && !int_block) begin
          state_nx   = ST_REQ;
          n_busrq_nx = 1'b0;
          // Sole requester wins outright; a tie goes to whoever was not granted last.
          if (req == 2'b11) win_nx = ~last;
          else              win_nx = req[1];
        end
      end
      ST_REQ: begin
        if (!req[win]) begin
          // Requester gave up before BUSAK: abandon without touching gnt or last.
          state_nx   = ST_RELEASE;
          n_busrq_nx = 1'b1;
        end else if (!n_busak) begin
          state_nx = ST_GRANT;
          gnt_nx   = win ? 2'b10 : 2'b01;
          last_nx  = win;
          bcnt_nx  = '0;
        end
      end
      ST_GRANT: begin
        bcnt_nx = bcnt + BW'(1);
        // BUSAK rising here is a protocol error; drop the grant just like a normal release.
        if (!req[win] || n_busak || (bcnt == BW'(MAX_BURST - 1))) begin
          state_nx   = ST_RELEASE;
          gnt_nx     = 2'b00;
          n_busrq_nx = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (n_busak) begin
          state_nx = ST_GAP;
          gcnt_nx  = '0;
        end
      end
      ST_GAP: begin
        gcnt_nx = gcnt + GW'(1);
        if (gcnt == GW'(MIN_GAP - 1)) state_nx = ST_IDLE;
      end
      default: begin
        state_nx   = ST_IDLE;
        n_busrq_nx = 1'b1;
        gnt_nx     = 2'b00;
      end
    endcase
  end

  // State and output registers; CPU reset aborts everything synchronously on a clkcpu edge.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      win     <= 1'b0;
      last    <= 1'b1;
      bcnt    <= '0;
      gcnt    <= '0;
      n_busrq <= 1'b1;
      gnt     <= 2'b00;
      busy    <= 1'b0;
    end else if (!n_rstcpu) begin
      state   <= ST_IDLE;
      win     <= 1'b0;
      last    <= 1'b1;
      bcnt    <= '0;
      gcnt    <= '0;
      n_busrq <= 1'b1;
      gnt     <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      win     <= win_nx;
      last    <= last_nx;
      bcnt    <= bcnt_nx;
      gcnt    <= gcnt_nx;
      n_busrq <= n_busrq_nx;
      gnt     <= gnt_nx;
      busy    <= (state_nx != ST_IDLE);
    end
  end

endmodule
